// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings and frame constants for the UART endpoint
package uart_pkg;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: synchronised 8N1 receiver with a single-byte holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       rx_take,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_t state, state_n;
  logic rx_s1, rx_s2, rx_prev, stop_hit, load;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  logic [7:0] sh, sh_n;
  always_comb begin
    state_n = state;
    cnt_n = (cnt == '0) ? cnt : cnt - CW'(1);
    bit_n = bit_idx;
    sh_n = sh;
    stop_hit = 1'b0;
    unique case (state)
      RX_IDLE: if (rx_prev && !rx_s2) begin
        state_n = RX_START;
        cnt_n = CNT_HALF;
      end
      RX_START: if (cnt == '0) begin
        state_n = rx_s2 ? RX_IDLE : RX_DATA;
        cnt_n = CNT_MAX;
        bit_n = '0;
      end
      RX_DATA: if (cnt == '0) begin
        sh_n = {rx_s2, sh[7:1]};
        cnt_n = CNT_MAX;
        bit_n = bit_idx + BW'(1);
        state_n = (bit_idx == BW'(DATA_BITS - 1)) ? RX_STOP : RX_DATA;
      end
      RX_STOP: if (cnt == '0) begin
        stop_hit = 1'b1;
        state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end
  assign load = stop_hit && rx_s2 && (!rx_valid || rx_take);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      state <= RX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      rx_overrun <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      if (load) rx_byte <= sh;
      rx_valid <= load || (rx_valid && !rx_take);
      rx_overrun <= stop_hit && rx_s2 && rx_valid && !rx_take;
      rx_frame_err <= stop_hit && !rx_s2;
    end
  end
endmodule

// File: rtl/uart_port.sv
// uart_port: memory-mapped UART with TX FIFO, 8N1 serialiser and stall handshake
module uart_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_write,
  input  logic       uart_read,
  output logic       uart_stall,
  output logic [7:0] rd_data,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       txd,
  input  logic       rxd
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] PTR_ONE = 1;
  logic [7:0] mem [TX_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, rx_valid, rx_take, txd_n, frame_done;
  logic [7:0] rx_byte, sh, sh_n;
  tx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_idx, bit_n;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = wr_ptr == rd_ptr;
  assign uart_stall = (uart_write && full) || (uart_read && !rx_valid);
  assign push = uart_write && !uart_stall;
  assign rx_take = uart_read && !uart_stall;
  assign rd_data = rx_byte;
  assign frame_done = state == TX_STOP && cnt == '0 && bit_idx == BW'(STOP_BITS - 1);
  assign pop = !empty && (state == TX_IDLE || frame_done);
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= uart_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
  // a pop always launches a start bit, so the next frame follows the stop bit with no gap
  always_comb begin
    state_n = state;
    cnt_n = (cnt == '0) ? cnt : cnt - CW'(1);
    bit_n = bit_idx;
    sh_n = sh;
    txd_n = txd;
    unique case (state)
      TX_IDLE: ;
      TX_START: if (cnt == '0) begin
        state_n = TX_DATA;
        cnt_n = CNT_MAX;
        bit_n = '0;
        txd_n = sh[0];
      end
      TX_DATA: if (cnt == '0) begin
        cnt_n = CNT_MAX;
        state_n = (bit_idx == BW'(DATA_BITS - 1)) ? TX_STOP : TX_DATA;
        bit_n = (bit_idx == BW'(DATA_BITS - 1)) ? '0 : bit_idx + BW'(1);
        sh_n = sh >> 1;
        txd_n = (bit_idx == BW'(DATA_BITS - 1)) ? 1'b1 : sh[1];
      end
      TX_STOP: if (cnt == '0) begin
        state_n = frame_done ? TX_IDLE : TX_STOP;
        cnt_n = frame_done ? cnt : CNT_MAX;
        bit_n = frame_done ? bit_idx : bit_idx + BW'(1);
      end
      default: state_n = TX_IDLE;
    endcase
    if (pop) begin
      state_n = TX_START;
      cnt_n = CNT_MAX;
      sh_n = mem[rd_ptr[AW-1:0]];
      txd_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= TX_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      txd <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      sh <= sh_n;
      txd <= txd_n;
    end
  end
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .rx_take(rx_take),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err)
  );
endmodule
